// File: rtl/fpalu_bist.sv
// fpalu_bist -- hardware stimulus engine and signature compactor for FPALU.
//
// Streams N_VEC operand pairs into the ALU, sourced either from the fp16
// operand memories (dmem -> A, cmem -> B) or from a 32-bit Galois LFSR.
// Each pair is converted to the ALU's sign / 6-bit exponent / 22-bit
// denormal-mantissa format. Every ALU result is folded into a 32-bit MISR.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, abort      begin a run (IDLE only) / stop a run without done
//   mode[1:0]         [1] 0=memory 1=LFSR source, [0] 0=MUL 1=ADD
//   daddr, caddr      registered memory read addresses (vector index)
//   din, cin          fp16 words read asynchronously from dmem / cmem
//   opcode            {1'b1, mode[0]} latched at start
//   alu_valid         operand registers hold a live vector
//   a_*, b_*          registered ALU operands
//   y_*               ALU result, LATENCY cycles after alu_valid
//   busy, done        run in progress / one-cycle completion pulse
//   vec_count         results captured in this run
//   signature         MISR value, holds after the run
module fpalu_bist #(
    parameter int          ADDR_W  = 9,
    parameter int          N_VEC   = 200,
    parameter int          LATENCY = 2,
    parameter logic [31:0] SEED    = 32'hACE1_2021
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    output logic [ADDR_W-1:0] daddr,
    output logic [ADDR_W-1:0] caddr,
    input  logic [15:0]       din,
    input  logic [15:0]       cin,
    output logic [1:0]        opcode,
    output logic              alu_valid,
    output logic              a_sgn,
    output logic [5:0]        a_exp,
    output logic [21:0]       a_man_dn,
    output logic              b_sgn,
    output logic [5:0]        b_exp,
    output logic [21:0]       b_man_dn,
    input  logic              y_sgn,
    input  logic [5:0]        y_exp,
    input  logic [21:0]       y_man_dn,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   vec_count,
    output logic [31:0]       signature
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q;
    logic                src_lfsr_q;
    logic [31:0]         lfsr_q;
    logic                last_idx;
    logic                abort_act;
    logic                start_act;
    logic                cap_v;
    logic                pipe_busy;
    logic [28:0]         op_a, op_b;
    logic [31:0]         res;

    // Pack one operand: exponent is rebiased by +10 (mod 64), mantissa
    // choice depends on whether the ALU is adding (forced normal) or
    // multiplying.
    function automatic logic [28:0] pack_op(input logic        s,
                                            input logic [4:0]  e,
                                            input logic [21:0] man_mul,
                                            input logic [21:0] man_add,
                                            input logic        is_add);
        pack_op = {s, {1'b0, e} + 6'd10, is_add ? man_add : man_mul};
    endfunction

    // Galois LFSR, right shift, taps 32'h80200003.
    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        lfsr_step = x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
    endfunction

    // MISR update with the CRC-32 polynomial.
    function automatic logic [31:0] misr_next(input logic [31:0] sig,
                                              input logic [31:0] d);
        misr_next = ({sig[30:0], 1'b0} ^ (sig[31] ? 32'h04C1_1DB7 : 32'h0)) ^ d;
    endfunction

    assign last_idx  = (idx_q == ADDR_W'(N_VEC - 1));
    assign abort_act = abort && (state_q != S_IDLE);
    assign start_act = start && (state_q == S_IDLE);
    assign daddr     = idx_q;
    assign caddr     = idx_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign res       = {3'b000, y_sgn, y_exp, y_man_dn};

    // Operand conversion. The B word from the LFSR is the half-swapped
    // state r = {lfsr[15:0], lfsr[31:16]}, so r[28] = lfsr[12],
    // r[26:22] = lfsr[10:6], r[21:0] = {lfsr[5:0], lfsr[31:16]}.
    always_comb begin
        op_a = '0;
        op_b = '0;
        if (src_lfsr_q) begin
            op_a = pack_op(lfsr_q[28], lfsr_q[26:22], lfsr_q[21:0],
                           {1'b1, lfsr_q[20:0]}, opcode[0]);
            op_b = pack_op(lfsr_q[12], lfsr_q[10:6], {lfsr_q[5:0], lfsr_q[31:16]},
                           {1'b1, lfsr_q[4:0], lfsr_q[31:16]}, opcode[0]);
        end else begin
            op_a = pack_op(din[15], din[14:10], {12'b0, din[9:0]},
                           {1'b1, 11'b0, din[9:0]}, opcode[0]);
            op_b = pack_op(cin[15], cin[14:10], {12'b0, cin[9:0]},
                           {1'b1, 11'b0, cin[9:0]}, opcode[0]);
        end
    end

    // Delayed valid: the result of a vector whose operands are live in
    // cycle c is sampled at the end of cycle c+LATENCY-1, so LATENCY-1
    // register stages follow alu_valid.
    generate
        if (LATENCY > 1) begin : g_vld
            localparam int VW = LATENCY - 1;
            logic [VW-1:0] vld_p;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_p <= '0;
                end else if (start_act || abort_act) begin
                    vld_p <= '0;
                end else begin
                    vld_p <= VW'({vld_p, alu_valid});
                end
            end
            assign cap_v     = vld_p[VW-1];
            assign pipe_busy = alu_valid | (|vld_p);
        end else begin : g_novld
            assign cap_v     = alu_valid;
            assign pipe_busy = alu_valid;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN: begin
                if (abort)         state_d = S_IDLE;
                else if (last_idx) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort)           state_d = S_IDLE;
                else if (!pipe_busy) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Stage p0 -> p1: address/LFSR drive the operand registers; results
    // are compacted into the MISR as their delayed valid arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q      <= '0;
            src_lfsr_q <= 1'b0;
            opcode     <= 2'b00;
            lfsr_q     <= SEED;
            alu_valid  <= 1'b0;
            a_sgn      <= 1'b0;
            a_exp      <= '0;
            a_man_dn   <= '0;
            b_sgn      <= 1'b0;
            b_exp      <= '0;
            b_man_dn   <= '0;
            vec_count  <= '0;
            signature  <= '0;
        end else if (start_act) begin
            idx_q      <= '0;
            src_lfsr_q <= mode[1];
            opcode     <= {1'b1, mode[0]};
            lfsr_q     <= SEED;
            alu_valid  <= 1'b0;
            vec_count  <= '0;
            signature  <= '0;
        end else if (abort_act) begin
            alu_valid <= 1'b0;
        end else begin
            if (state_q == S_RUN) begin
                {a_sgn, a_exp, a_man_dn} <= op_a;
                {b_sgn, b_exp, b_man_dn} <= op_b;
                alu_valid                <= 1'b1;
                lfsr_q                   <= lfsr_step(lfsr_q);
                if (!last_idx) idx_q <= idx_q + 1'b1;
            end else begin
                alu_valid <= 1'b0;
            end
            if (cap_v) begin
                signature <= misr_next(signature, res);
                vec_count <= vec_count + 1'b1;
            end
        end
    end

endmodule
